// File: rtl/stream_mux_if.sv
// Bundle of N valid/ready input streams plus the single registered output stream.
// The slave view belongs to the multiplexer; the master view belongs to whatever drives it.
interface stream_mux_if #(
  parameter int WIDTH = 8,
  parameter int N     = 4
);
  localparam int SELW = $clog2(N);

  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic               mode;
  logic [SELW-1:0]    sel;
  logic [WIDTH-1:0]   out_data;
  logic [SELW-1:0]    out_ch;
  logic               out_valid;
  logic               out_ready;

  modport master (
    output in_data, in_valid, mode, sel, out_ready,
    input  in_ready, out_data, out_ch, out_valid
  );

  modport slave (
    input  in_data, in_valid, mode, sel, out_ready,
    output in_ready, out_data, out_ch, out_valid
  );
endinterface

// File: rtl/stream_mux_n.sv
// N-channel registered stream multiplexer: fixed-select or round-robin grant feeding
// one output register that carries the beat and its source channel.
module stream_mux_n #(
  parameter int WIDTH = 8,
  parameter int N     = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  stream_mux_if.slave bus
);
  localparam int              SELW = $clog2(N);
  localparam logic [SELW-1:0] LAST = SELW'(N - 1);

  logic [SELW-1:0]  ptr;
  logic [SELW-1:0]  gnt;
  logic [SELW-1:0]  ptr_next;
  logic             gnt_vld;
  logic             load;
  logic [WIDTH-1:0] gnt_data;
  int               rr_idx;

  assign load     = !bus.out_valid || bus.out_ready;
  // Pointer wraps at N, not at 2**SELW, so non-power-of-two channel counts stay fair.
  assign ptr_next = (gnt == LAST) ? '0 : gnt + SELW'(1);

  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    rr_idx  = 0;
    if (!bus.mode) begin
      for (int i = 0; i < N; i++) begin
        if (bus.sel == SELW'(i) && bus.in_valid[i]) begin
          gnt     = SELW'(i);
          gnt_vld = 1'b1;
        end
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        rr_idx = (int'(ptr) + k) % N;
        if (!gnt_vld && bus.in_valid[rr_idx]) begin
          gnt     = SELW'(rr_idx);
          gnt_vld = 1'b1;
        end
      end
    end
  end

  always_comb begin
    gnt_data     = '0;
    bus.in_ready = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt == SELW'(i)) begin
        gnt_data        = bus.in_data[i*WIDTH +: WIDTH];
        bus.in_ready[i] = load && gnt_vld && rst_n;
      end
    end
  end

  // ---- output register stage ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_ch    <= '0;
      ptr           <= '0;
    end else if (load) begin
      bus.out_valid <= gnt_vld;
      if (gnt_vld) begin
        bus.out_data <= gnt_data;
        bus.out_ch   <= gnt;
        if (bus.mode) ptr <= ptr_next;
      end
    end
  end
endmodule

// File: tb/tb_stream_mux_n.sv
// Bench for stream_mux_n: directed scenarios on 4- and 3-channel instances plus a
// randomized run on the 4-channel instance against a distance-based arbitration model.
module tb_stream_mux_n;
  localparam int W = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stream_mux_if #(.WIDTH(W), .N(4)) b4 ();
  stream_mux_if #(.WIDTH(W), .N(3)) b3 ();

  stream_mux_n #(.WIDTH(W), .N(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4.slave));
  stream_mux_n #(.WIDTH(W), .N(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3.slave));

  int errors = 0;
  int checks = 0;

  // Model state for the randomized run
  logic       m_valid;
  logic [7:0] m_data;
  int         m_ch;
  int         m_ptr;

  // Winner is the valid channel at the smallest forward distance from ptr.
  function automatic int pick(input bit md, input int s, input logic [3:0] v, input int p);
    int best  = -1;
    int bestd = 99;
    if (!md) return (s < 4 && v[s]) ? s : -1;
    for (int i = 0; i < 4; i++) begin
      if (v[i] && ((i - p + 4) % 4) < bestd) begin
        bestd = (i - p + 4) % 4;
        best  = i;
      end
    end
    return best;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    b4.in_valid = '0; b3.in_valid = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    b4.in_data = 32'h44332211; b4.in_valid = 4'hF; b4.mode = 1'b1; b4.sel = '0; b4.out_ready = 1'b1;
    b3.in_data = 24'hC3B2A1;   b3.in_valid = 3'h7; b3.mode = 1'b1; b3.sel = '0; b3.out_ready = 1'b1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++; if (b4.in_ready !== 4'b0) begin errors++; $display("FAIL reset_in_ready4: got %b want 0000", b4.in_ready); end
    checks++; if (b3.in_ready !== 3'b0) begin errors++; $display("FAIL reset_in_ready3: got %b want 000", b3.in_ready); end
    checks++; if (b4.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", b4.out_valid); end
    checks++; if (b4.out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h want 00", b4.out_data); end
    checks++; if (b4.out_ch !== 2'd0) begin errors++; $display("FAIL reset_out_ch: got %0d want 0", b4.out_ch); end
    rst_n = 1'b1;
    #1;
    checks++; if (b4.in_ready !== 4'b0001) begin errors++; $display("FAIL release_in_ready: got %b want 0001", b4.in_ready); end
    @(posedge clk); #1;
    checks++; if (b4.out_valid !== 1'b1 || b4.out_ch !== 2'd0 || b4.out_data !== 8'h11)
      begin errors++; $display("FAIL first_beat: got v=%b ch=%0d d=%h want v=1 ch=0 d=11", b4.out_valid, b4.out_ch, b4.out_data); end
    b3.in_valid = '0;
  endtask

  task automatic test_fixed();
    do_reset();
    b4.mode = 1'b0; b4.sel = 2'd2; b4.in_data = 32'h44A52211; b4.in_valid = 4'hF; b4.out_ready = 1'b1;
    #1;
    checks++; if (b4.in_ready !== 4'b0100) begin errors++; $display("FAIL fixed_in_ready: got %b want 0100", b4.in_ready); end
    @(posedge clk); #1;
    checks++; if (b4.out_valid !== 1'b1 || b4.out_data !== 8'hA5 || b4.out_ch !== 2'd2)
      begin errors++; $display("FAIL fixed_beat: got v=%b d=%h ch=%0d want v=1 d=a5 ch=2", b4.out_valid, b4.out_data, b4.out_ch); end
    b4.sel = 2'd3; b4.in_valid = 4'b0111;
    #1;
    checks++; if (b4.in_ready !== 4'b0000) begin errors++; $display("FAIL fixed_nogrant_ready: got %b want 0000", b4.in_ready); end
    @(posedge clk); #1;
    checks++; if (b4.out_valid !== 1'b0 || b4.out_data !== 8'hA5 || b4.out_ch !== 2'd2)
      begin errors++; $display("FAIL fixed_nogrant: got v=%b d=%h ch=%0d want v=0 d=a5 ch=2", b4.out_valid, b4.out_data, b4.out_ch); end
  endtask

  task automatic test_round_robin();
    logic [1:0] alt [4] = '{2'd1, 2'd3, 2'd1, 2'd3};
    do_reset();
    b4.mode = 1'b1; b4.in_data = 32'h44332211; b4.in_valid = 4'hF; b4.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      checks++; if (b4.out_valid !== 1'b1 || b4.out_ch !== 2'(i % 4) || b4.out_data !== 8'(8'h11 * (i % 4 + 1)))
        begin errors++; $display("FAIL rr_all beat %0d: got v=%b ch=%0d d=%h want ch=%0d", i, b4.out_valid, b4.out_ch, b4.out_data, i % 4); end
    end
    b4.in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++; if (b4.out_valid !== 1'b1 || b4.out_ch !== alt[i])
        begin errors++; $display("FAIL rr_sparse beat %0d: got v=%b ch=%0d want ch=%0d", i, b4.out_valid, b4.out_ch, alt[i]); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    b4.mode = 1'b1; b4.in_data = 32'h44332211; b4.in_valid = 4'hF; b4.out_ready = 1'b1;
    @(posedge clk); #1;
    b4.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (b4.in_ready !== 4'b0000) begin errors++; $display("FAIL stall_ready cycle %0d: got %b want 0000", i, b4.in_ready); end
      @(posedge clk); #1;
      checks++; if (b4.out_valid !== 1'b1 || b4.out_ch !== 2'd0 || b4.out_data !== 8'h11)
        begin errors++; $display("FAIL stall_hold cycle %0d: got v=%b ch=%0d d=%h want v=1 ch=0 d=11", i, b4.out_valid, b4.out_ch, b4.out_data); end
    end
    b4.out_ready = 1'b1;
    #1;
    checks++; if (b4.in_ready !== 4'b0010) begin errors++; $display("FAIL drain_accept_ready: got %b want 0010", b4.in_ready); end
    @(posedge clk); #1;
    checks++; if (b4.out_valid !== 1'b1 || b4.out_ch !== 2'd1 || b4.out_data !== 8'h22)
      begin errors++; $display("FAIL drain_accept_beat: got v=%b ch=%0d d=%h want v=1 ch=1 d=22", b4.out_valid, b4.out_ch, b4.out_data); end
  endtask

  task automatic test_wrap_n3();
    do_reset();
    b4.in_valid = '0;
    b3.mode = 1'b1; b3.sel = '0; b3.in_data = 24'hC3B2A1; b3.in_valid = 3'b010; b3.out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (b3.out_valid !== 1'b1 || b3.out_ch !== 2'd1)
      begin errors++; $display("FAIL n3_setup: got v=%b ch=%0d want v=1 ch=1", b3.out_valid, b3.out_ch); end
    b3.in_valid = 3'b011;
    #1;
    checks++; if (b3.in_ready !== 3'b001) begin errors++; $display("FAIL n3_wrap_ready: got %b want 001", b3.in_ready); end
    @(posedge clk); #1;
    checks++; if (b3.out_ch !== 2'd0 || b3.out_data !== 8'hA1)
      begin errors++; $display("FAIL n3_wrap_beat: got ch=%0d d=%h want ch=0 d=a1", b3.out_ch, b3.out_data); end
    #1;
    checks++; if (b3.in_ready !== 3'b010) begin errors++; $display("FAIL n3_ptr_after_wrap: got %b want 010", b3.in_ready); end
    @(posedge clk); #1;
    b3.mode = 1'b0; b3.sel = 2'd3; b3.in_valid = 3'b111;
    #1;
    checks++; if (b3.in_ready !== 3'b000) begin errors++; $display("FAIL n3_sel3_ready: got %b want 000", b3.in_ready); end
    @(posedge clk); #1;
    checks++; if (b3.out_valid !== 1'b0) begin errors++; $display("FAIL n3_sel3_valid: got %b want 0", b3.out_valid); end
    b3.in_valid = '0;
  endtask

  task automatic test_mode_switch();
    do_reset();
    b4.mode = 1'b1; b4.in_data = 32'h44332211; b4.in_valid = 4'hF; b4.out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++; if (b4.out_ch !== 2'(i)) begin errors++; $display("FAIL switch_rr beat %0d: got ch=%0d want %0d", i, b4.out_ch, i); end
    end
    b4.mode = 1'b0; b4.sel = 2'd0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++; if (b4.out_valid !== 1'b1 || b4.out_ch !== 2'd0)
        begin errors++; $display("FAIL switch_fixed beat %0d: got v=%b ch=%0d want v=1 ch=0", i, b4.out_valid, b4.out_ch); end
    end
    b4.mode = 1'b1;
    #1;
    checks++; if (b4.in_ready !== 4'b0100) begin errors++; $display("FAIL switch_back_ready: got %b want 0100", b4.in_ready); end
    @(posedge clk); #1;
    checks++; if (b4.out_ch !== 2'd2) begin errors++; $display("FAIL switch_back_beat: got ch=%0d want 2", b4.out_ch); end
  endtask

  task automatic test_random();
    int         g;
    logic       ld;
    logic [3:0] exp_rdy;
    do_reset();
    m_valid = 1'b0; m_data = '0; m_ch = 0; m_ptr = 0;
    for (int c = 0; c < 400; c++) begin
      b4.mode      = 1'($urandom_range(0, 1));
      b4.sel       = 2'($urandom_range(0, 3));
      b4.in_valid  = 4'($urandom);
      b4.in_data   = $urandom;
      b4.out_ready = ($urandom_range(0, 3) != 0);
      rst_n        = ($urandom_range(0, 39) != 0);
      if (!rst_n) begin m_valid = 1'b0; m_data = '0; m_ch = 0; m_ptr = 0; end
      g       = pick(b4.mode, int'(b4.sel), b4.in_valid, m_ptr);
      ld      = !m_valid || b4.out_ready;
      exp_rdy = (rst_n && ld && g >= 0) ? 4'(1 << g) : 4'b0000;
      #1;
      checks++; if (b4.in_ready !== exp_rdy)
        begin errors++; $display("FAIL rand_ready cycle %0d: got %b want %b", c, b4.in_ready, exp_rdy); end
      @(posedge clk);
      if (rst_n && ld) begin
        if (g >= 0) begin
          m_valid = 1'b1;
          m_data  = b4.in_data[g*8 +: 8];
          m_ch    = g;
          if (b4.mode) m_ptr = (g + 1) % 4;
        end else begin
          m_valid = 1'b0;
        end
      end
      #1;
      checks++; if (b4.out_valid !== m_valid || b4.out_data !== m_data || b4.out_ch !== 2'(m_ch))
        begin errors++; $display("FAIL rand_out cycle %0d: got v=%b d=%h ch=%0d want v=%b d=%h ch=%0d",
                                 c, b4.out_valid, b4.out_data, b4.out_ch, m_valid, m_data, m_ch); end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_round_robin();
    test_backpressure();
    test_wrap_n3();
    test_mode_switch();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
